// File: rtl/bw_input_conditioner.sv
// Cabinet input front end: 3 kHz tick/clock, 2-flop synchronisers, per-bit debounce,
// coin pulse shaping and per-game packing of the core's input_0/3/4 bytes.
module bw_input_conditioner #(
  parameter int CLK_HZ           = 12000000,
  parameter int TICK_HZ          = 3000,
  parameter int DEB_TICKS        = 4,
  parameter int COIN_PULSE_TICKS = 96,
  parameter int COIN_GAP_TICKS   = 96
) (
  input  logic        clk_12,
  input  logic        RESET_L,
  input  logic [1:0]  mod_sel,
  input  logic [11:0] joy_raw,
  input  logic [1:0]  diag_sw,
  output logic        clk3k,
  output logic        coin_pulse,
  output logic [7:0]  input_0,
  output logic [7:0]  input_3,
  output logic [7:0]  input_4
);

  localparam int HALF     = CLK_HZ / (2 * TICK_HZ);
  localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DEB_W    = $clog2(DEB_TICKS + 1);
  localparam int CNT_MAX  = (COIN_PULSE_TICKS > COIN_GAP_TICKS) ? COIN_PULSE_TICKS : COIN_GAP_TICKS;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // Conditioned bits: [10:0] joy_raw[10:0], [11] diag_sw[0], [12] diag_sw[1].
  localparam int NB       = 13;
  localparam int COIN_BIT = 10;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  logic [DIV_W-1:0] div;
  logic             div_tc;
  logic             tick;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    deb;
  logic [DEB_W-1:0] deb_cnt [NB];
  coin_state_t      state;
  coin_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             coin_prev;
  logic             armed;
  logic             coin_rise;
  logic             unused_ok;

  assign unused_ok = joy_raw[11];

  function automatic logic [23:0] pack_bytes(input logic [1:0] m, input logic [9:0] j,
                                             input logic [1:0] dg, input logic c, input logic ck);
    logic [7:0] b0;
    logic [7:0] b3;
    logic [7:0] b4;
    b0 = {ck, 1'b0, ~dg[0], ~dg[1], 1'b1, 1'b1, ~c, 1'b1};
    b3 = 8'hFF;
    b4 = 8'hFF;
    case (m)
      2'd0: begin
        b3 = {4'hF, ~j[3], ~j[2], ~j[1], ~j[0]};
        b4 = {1'b1, ~j[9], ~j[8], 1'b1, ~j[7], ~j[6], ~j[5], ~j[4]};
      end
      2'd1: begin
        b3 = {3'b111, ~j[5], ~j[1], ~j[0], ~j[4], ~j[6]};
        b4 = {1'b1, ~j[9], ~j[8], 5'b11111};
      end
      2'd2: begin
        b3 = {1'b0, j[9], j[8], j[5], j[6], j[4], j[0], j[1]};
        b4 = 8'hFF;
      end
      default: b0 = 8'hFF;
    endcase
    return {b0, b3, b4};
  endfunction

  assign div_tc = (div == DIV_W'(HALF - 1));
  assign tick   = div_tc & ~clk3k;

  always_ff @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) begin
      div   <= '0;
      clk3k <= 1'b0;
    end else if (div_tc) begin
      div   <= '0;
      clk3k <= ~clk3k;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Stage p0/p1: two-flop synchroniser for every asynchronous cabinet bit
  always_ff @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {diag_sw, joy_raw[10:0]};
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: a bit must disagree with its debounced value for DEB_TICKS ticks to flip
  always_ff @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) begin
      deb <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (tick) begin
          if (deb_cnt[i] == DEB_W'(DEB_TICKS - 1)) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // A coin held through reset must be seen released (at a tick, after the
  // synchroniser has refilled) before any rise is honoured.
  assign coin_rise = deb[COIN_BIT] & ~coin_prev & armed;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (coin_rise) begin
          state_nxt = PULSE;
          cnt_nxt   = CNT_W'(COIN_PULSE_TICKS - 1);
        end
      end
      PULSE: begin
        if (tick) begin
          if (cnt == '0) begin
            state_nxt = GAP;
            cnt_nxt   = CNT_W'(COIN_GAP_TICKS - 1);
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      GAP: begin
        if (tick && (cnt != '0)) cnt_nxt = cnt - 1'b1;
        if ((cnt == '0) && !deb[COIN_BIT]) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) begin
      state      <= IDLE;
      cnt        <= '0;
      coin_prev  <= 1'b0;
      armed      <= 1'b0;
      coin_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      coin_prev  <= deb[COIN_BIT];
      coin_pulse <= (state_nxt == PULSE);
      if (tick && !sync_p1[COIN_BIT]) armed <= 1'b1;
    end
  end

  // Stage p2: registered per-game packing; mod_sel is used directly, no retiming
  always_ff @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) begin
      input_0 <= 8'h3F;
      input_3 <= 8'hFF;
      input_4 <= 8'hFF;
    end else begin
      {input_0, input_3, input_4} <= pack_bytes(mod_sel, deb[9:0], deb[12:11], coin_pulse, clk3k);
    end
  end

endmodule

// File: tb/tb_bw_input_conditioner.sv
// Randomised self-checking bench for bw_input_conditioner, run with a fast tick
// (HALF=4 clocks) and short coin pulse/gap so every scenario fits a short run.
module tb_bw_input_conditioner;

  localparam int CLK_HZ = 24000;
  localparam int TICK_HZ = 3000;
  localparam int DEB = 4;
  localparam int PT = 8;
  localparam int GT = 8;
  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int TP = 2 * HALF;

  logic        clk_12 = 1'b0;
  logic        RESET_L;
  logic [1:0]  mod_sel;
  logic [11:0] joy_raw;
  logic [1:0]  diag_sw;
  logic        clk3k;
  logic        coin_pulse;
  logic [7:0]  input_0;
  logic [7:0]  input_3;
  logic [7:0]  input_4;

  bw_input_conditioner #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_TICKS(DEB),
    .COIN_PULSE_TICKS(PT), .COIN_GAP_TICKS(GT)
  ) dut (
    .clk_12(clk_12), .RESET_L(RESET_L), .mod_sel(mod_sel), .joy_raw(joy_raw),
    .diag_sw(diag_sw), .clk3k(clk3k), .coin_pulse(coin_pulse),
    .input_0(input_0), .input_3(input_3), .input_4(input_4)
  );

  always #5 clk_12 = ~clk_12;

  // Clock edges since reset release: the bench's own time base for clk3k.
  int ncyc;
  always @(posedge clk_12 or negedge RESET_L) begin
    if (!RESET_L) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  int cur_w = 0;
  int last_w = 0;
  logic ck_s = 1'b0, ck_prev = 1'b0, cp_s = 1'b0, cp_prev = 1'b0;

  // Expected {input_0, input_3, input_4} from the game pin tables.
  // d: [11:0] logical buttons in joy_raw order, [12] diag0, [13] diag1.
  function automatic logic [23:0] model_bytes(input logic [1:0] m, input logic [13:0] d,
                                              input logic c, input int n);
    logic r, l, dn, u, fr, fl, fd, fu, s1, s2, g0, g1, ck;
    logic [7:0] b0, b3, b4;
    r = d[0]; l = d[1]; dn = d[2]; u = d[3];
    fr = d[4]; fl = d[5]; fd = d[6]; fu = d[7];
    s1 = d[8]; s2 = d[9]; g0 = d[12]; g1 = d[13];
    ck = (n == 0) ? 1'b0 : (((n - 1) / HALF) % 2 == 1);
    b0 = {ck, 1'b0, !g0, !g1, 1'b1, 1'b1, !c, 1'b1};
    if (m == 2'd0) begin
      b3 = {4'b1111, !u, !dn, !l, !r};
      b4 = {1'b1, !s2, !s1, 1'b1, !fu, !fd, !fl, !fr};
    end else if (m == 2'd1) begin
      b3 = {3'b111, !fl, !l, !r, !fr, !fd};
      b4 = {1'b1, !s2, !s1, 5'b11111};
    end else if (m == 2'd2) begin
      b3 = {1'b0, s2, s1, fl, fd, fr, r, l};
      b4 = 8'hFF;
    end else begin
      b0 = 8'hFF; b3 = 8'hFF; b4 = 8'hFF;
    end
    return {b0, b3, b4};
  endfunction

  task automatic step();
    ck_prev = ck_s;
    cp_prev = cp_s;
    @(negedge clk_12);
    ck_s = clk3k;
    cp_s = coin_pulse;
    if (cp_s && !cp_prev) begin
      pulse_count++;
      cur_w = 1;
    end else if (cp_s) begin
      cur_w++;
    end
    if (!cp_s && cp_prev) last_w = cur_w;
  endtask

  // Advance to the first sample after the next clk3k rise (i.e. just after a tick).
  task automatic wait_tick();
    int g = 0;
    do begin
      step();
      g++;
    end while (!(ck_s && !ck_prev) && g < 3 * HALF);
    if (!(ck_s && !ck_prev)) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout no clk3k rise within %0d clocks", g);
    end
  endtask

  task automatic test_reset();
    logic exp_ck;
    logic [23:0] exp_b;
    RESET_L = 1'b0; mod_sel = 2'd0; joy_raw = '0; diag_sw = '0;
    #12;
    checks++; if (clk3k !== 1'b0) begin errors++; $display("FAIL rst_clk3k got %b exp 0", clk3k); end
    checks++; if (coin_pulse !== 1'b0) begin errors++; $display("FAIL rst_coin got %b exp 0", coin_pulse); end
    checks++; if (input_0 !== 8'h3F) begin errors++; $display("FAIL rst_in0 got %h exp 3f", input_0); end
    checks++; if (input_3 !== 8'hFF) begin errors++; $display("FAIL rst_in3 got %h exp ff", input_3); end
    checks++; if (input_4 !== 8'hFF) begin errors++; $display("FAIL rst_in4 got %h exp ff", input_4); end
    @(negedge clk_12);
    RESET_L = 1'b1;
    for (int k = 0; k < 3 * TP; k++) begin
      step();
      exp_ck = ((ncyc / HALF) % 2 == 1);
      exp_b = model_bytes(2'd0, 14'd0, 1'b0, ncyc);
      checks++;
      if (clk3k !== exp_ck) begin errors++; $display("FAIL clk3k_phase n=%0d got %b exp %b", ncyc, clk3k, exp_ck); end
      checks++;
      if ({input_0, input_3, input_4} !== exp_b)
        begin errors++; $display("FAIL idle_bytes n=%0d got %h exp %h", ncyc, {input_0, input_3, input_4}, exp_b); end
    end
  endtask

  task automatic test_debounce_r();
    mod_sel = 2'd0;
    wait_tick();
    joy_raw[0] = 1'b1;
    repeat (DEB - 1) wait_tick();
    checks++; if (input_3 !== 8'hFF) begin errors++; $display("FAIL r_early got %h exp ff", input_3); end
    wait_tick();
    checks++; if (input_3 !== 8'hFF) begin errors++; $display("FAIL r_latency got %h exp ff", input_3); end
    step();
    checks++; if (input_3 !== 8'hFE) begin errors++; $display("FAIL r_held got %h exp fe", input_3); end
    joy_raw[0] = 1'b0;
    repeat (DEB + 1) wait_tick();
    step();
    checks++; if (input_3 !== 8'hFF) begin errors++; $display("FAIL r_release got %h exp ff", input_3); end
    wait_tick();
    joy_raw[0] = 1'b1;
    repeat (DEB - 1) wait_tick();
    joy_raw[0] = 1'b0;
    for (int k = 0; k < DEB + 2; k++) begin
      wait_tick();
      checks++; if (input_3 !== 8'hFF) begin errors++; $display("FAIL r_glitch got %h exp ff", input_3); end
    end
  endtask

  task automatic test_random_buttons();
    logic [13:0] mask;
    logic [1:0]  m;
    int          len;
    logic [23:0] exp_b;
    for (int it = 0; it < 12; it++) begin
      m = 2'($urandom_range(0, 2));
      mask = 14'($urandom) & 14'h33FF;
      len = $urandom_range(1, 7);
      mod_sel = m;
      wait_tick();
      joy_raw = {2'b00, mask[9:0]};
      diag_sw = mask[13:12];
      repeat (len) wait_tick();
      joy_raw = '0;
      diag_sw = '0;
      step();
      exp_b = model_bytes(m, (len >= DEB) ? mask : 14'd0, 1'b0, ncyc);
      checks++;
      if ({input_0, input_3, input_4} !== exp_b)
        begin errors++; $display("FAIL rand_hold it=%0d len=%0d got %h exp %h", it, len, {input_0, input_3, input_4}, exp_b); end
      repeat (DEB + 2) wait_tick();
      step();
      exp_b = model_bytes(m, 14'd0, 1'b0, ncyc);
      checks++;
      if ({input_0, input_3, input_4} !== exp_b)
        begin errors++; $display("FAIL rand_release it=%0d got %h exp %h", it, {input_0, input_3, input_4}, exp_b); end
    end
    mod_sel = 2'd0;
  endtask

  task automatic test_mod_switch();
    mod_sel = 2'd2;
    wait_tick();
    joy_raw[8] = 1'b1;
    joy_raw[1] = 1'b1;
    repeat (DEB + 1) wait_tick();
    step();
    checks++; if (input_3 !== 8'h21) begin errors++; $display("FAIL lunar_in3 got %h exp 21", input_3); end
    checks++; if (input_4 !== 8'hFF) begin errors++; $display("FAIL lunar_in4 got %h exp ff", input_4); end
    mod_sel = 2'd3;
    step();
    checks++;
    if ({input_0, input_3, input_4} !== 24'hFFFFFF)
      begin errors++; $display("FAIL mod3_bytes got %h exp ffffff", {input_0, input_3, input_4}); end
    mod_sel = 2'd0;
    step();
    checks++; if (input_3 !== 8'hFD) begin errors++; $display("FAIL back_mod0 got %h exp fd", input_3); end
    joy_raw = '0;
    repeat (DEB + 2) wait_tick();
  endtask

  task automatic test_coin_hold();
    int base;
    base = pulse_count;
    wait_tick();
    joy_raw[10] = 1'b1;
    for (int k = 0; k < 40 * TP; k++) begin
      step();
      checks++;
      if (input_0[1] !== ~cp_prev) begin errors++; $display("FAIL coin_bit k=%0d got %b exp %b", k, input_0[1], ~cp_prev); end
    end
    checks++;
    if (pulse_count - base != 1) begin errors++; $display("FAIL coin_hold_count got %0d exp 1", pulse_count - base); end
    checks++;
    if (last_w <= TP * (PT - 1) || last_w > TP * PT)
      begin errors++; $display("FAIL coin_width got %0d exp %0d..%0d", last_w, TP * (PT - 1) + 1, TP * PT); end
    joy_raw[10] = 1'b0;
    repeat (12) wait_tick();
    checks++;
    if (pulse_count - base != 1) begin errors++; $display("FAIL coin_release_count got %0d exp 1", pulse_count - base); end
  endtask

  task automatic test_coin_spacing(input int s, input int exp_n);
    int base;
    base = pulse_count;
    wait_tick();
    joy_raw[10] = 1'b1;
    repeat (5) wait_tick();
    joy_raw[10] = 1'b0;
    repeat (s - 5) wait_tick();
    joy_raw[10] = 1'b1;
    repeat (5) wait_tick();
    joy_raw[10] = 1'b0;
    repeat (30) wait_tick();
    checks++;
    if (pulse_count - base != exp_n)
      begin errors++; $display("FAIL coin_spacing s=%0d got %0d exp %0d", s, pulse_count - base, exp_n); end
  endtask

  task automatic test_reset_mid_pulse();
    int base;
    int g;
    wait_tick();
    joy_raw[10] = 1'b1;
    g = 0;
    while (!cp_s && g < 10 * TP) begin step(); g++; end
    checks++;
    if (!cp_s) begin errors++; $display("FAIL mid_pulse_start got %b exp 1", cp_s); end
    repeat (3 * TP) step();
    RESET_L = 1'b0;
    #1;
    checks++; if (coin_pulse !== 1'b0) begin errors++; $display("FAIL async_drop got %b exp 0", coin_pulse); end
    checks++; if (input_0 !== 8'h3F) begin errors++; $display("FAIL async_in0 got %h exp 3f", input_0); end
    step();
    RESET_L = 1'b1;
    base = pulse_count;
    repeat (20) wait_tick();
    checks++;
    if (pulse_count - base != 0) begin errors++; $display("FAIL held_after_reset got %0d exp 0", pulse_count - base); end
    joy_raw[10] = 1'b0;
    repeat (8) wait_tick();
    joy_raw[10] = 1'b1;
    repeat (6) wait_tick();
    joy_raw[10] = 1'b0;
    repeat (20) wait_tick();
    checks++;
    if (pulse_count - base != 1) begin errors++; $display("FAIL repress_after_reset got %0d exp 1", pulse_count - base); end
  endtask

  initial begin
    test_reset();
    test_debounce_r();
    test_random_buttons();
    test_mod_switch();
    test_coin_hold();
    test_coin_spacing($urandom_range(10, 14), 1);
    test_coin_spacing($urandom_range(22, 40), 2);
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
